// File: rtl/count_checker_pkg.sv
// rtl/count_checker_pkg.sv - shared constants, state encoding and helpers for count_checker
package count_checker_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int CNT_W     = 8;

  localparam logic [1:0] ST_ACQ   = 2'd0;
  localparam logic [1:0] ST_LOCK  = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  typedef enum logic [1:0] {
    ACQ   = ST_ACQ,
    LOCK  = ST_LOCK,
    TRACK = ST_TRACK,
    FAULT = ST_FAULT
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/count_checker_if.sv
// rtl/count_checker_if.sv - count stream input and status outputs of count_checker
interface count_checker_if
  import count_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] cnt_in;
  logic             clr_err;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic             wrap;
  logic [CNT_W-1:0] wrap_cnt;
  logic             match;

  modport master (
    output cnt_in, clr_err,
    input  locked, err, err_cnt, wrap, wrap_cnt, match
  );

  modport slave (
    input  cnt_in, clr_err,
    output locked, err, err_cnt, wrap, wrap_cnt, match
  );

endinterface

// File: rtl/count_checker_step_check.sv
// rtl/count_checker_step_check.sv - holds the previous sample and classifies each new step
module step_check
  import count_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             good_step,
  output logic             is_wrap
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= cnt_in;
  end

  // Increment is truncated to WIDTH so the all-ones to zero step counts as good.
  assign good_step = (cnt_in == WIDTH'(prev + 1'b1));
  assign is_wrap   = &prev;

endmodule

// File: rtl/count_checker.sv
// rtl/count_checker.sv - lock/track/fault monitor for a free-running count stream
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LOCK_CNT  = 2,
  parameter int MATCH_VAL = 31
) (
  input  logic          clk,
  input  logic          rst,
  count_checker_if.slave bus
);

  localparam int RUN_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  // run == LOCK_LAST means this good step is the LOCK_CNT-th in a row.
  localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_CNT - 1);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             match_q;
  logic             good_step;
  logic             is_wrap;

  step_check #(.WIDTH(WIDTH)) u_step_check (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (bus.cnt_in),
    .good_step (good_step),
    .is_wrap   (is_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACQ;
      run_q      <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      match_q    <= (bus.cnt_in == WIDTH'(MATCH_VAL));
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    locked_d   = locked_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    case (state_q)
      ACQ: begin
        state_d = LOCK;
        run_d   = '0;
      end
      LOCK: begin
        if (!good_step) begin
          run_d = '0;
        end else if (run_q == LOCK_LAST) begin
          state_d  = TRACK;
          locked_d = 1'b1;
          run_d    = '0;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
      TRACK: begin
        if (!good_step) begin
          state_d   = FAULT;
          err_d     = 1'b1;
          locked_d  = 1'b0;
          err_cnt_d = sat_inc(err_cnt_q);
        end else if (is_wrap) begin
          wrap_d     = 1'b1;
          wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
      end
      FAULT: begin
        if (bus.clr_err) begin
          state_d = ACQ;
          err_d   = 1'b0;
        end
      end
      default: state_d = ACQ;
    endcase
  end

  assign bus.locked   = locked_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.wrap     = wrap_q;
  assign bus.wrap_cnt = wrap_cnt_q;
  assign bus.match    = match_q;

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - directed self-checking bench for count_checker
module tb_count_checker;
  import count_checker_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  count_checker_if #(.WIDTH(5)) bus ();

  count_checker #(.WIDTH(5), .LOCK_CNT(2), .MATCH_VAL(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [4:0] c, input logic clr);
    bus.cnt_in  = c;
    bus.clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    bus.cnt_in  = '0;
    bus.clr_err = 1'b0;

    // reset state
    rst = 1'b1;
    step(5'd0, 1'b0);
    step(5'd0, 1'b0);
    chk("rst_locked",   32'(bus.locked),   32'd0);
    chk("rst_err",      32'(bus.err),      32'd0);
    chk("rst_err_cnt",  32'(bus.err_cnt),  32'd0);
    chk("rst_wrap",     32'(bus.wrap),     32'd0);
    chk("rst_wrap_cnt", 32'(bus.wrap_cnt), 32'd0);
    chk("rst_match",    32'(bus.match),    32'd0);
    rst = 1'b0;

    // clean lock: locked after the third edge
    step(5'd0, 1'b0);
    chk("lock_e1", 32'(bus.locked), 32'd0);
    step(5'd1, 1'b0);
    chk("lock_e2", 32'(bus.locked), 32'd0);
    step(5'd2, 1'b0);
    chk("lock_e3",         32'(bus.locked),  32'd1);
    chk("lock_err",        32'(bus.err),     32'd0);
    chk("lock_err_cnt",    32'(bus.err_cnt), 32'd0);

    // wrap and match
    for (int c = 3; c <= 29; c++) step(5'(c), 1'b0);
    step(5'd30, 1'b0);
    chk("pre_wrap_match", 32'(bus.match), 32'd0);
    step(5'd31, 1'b0);
    chk("match_31",   32'(bus.match), 32'd1);
    chk("wrap_at_31", 32'(bus.wrap),  32'd0);
    step(5'd0, 1'b0);
    chk("wrap_pulse",     32'(bus.wrap),     32'd1);
    chk("wrap_cnt_1",     32'(bus.wrap_cnt), 32'd1);
    chk("match_after_31", 32'(bus.match),    32'd0);
    step(5'd1, 1'b0);
    chk("wrap_one_cycle", 32'(bus.wrap),     32'd0);
    chk("wrap_cnt_hold",  32'(bus.wrap_cnt), 32'd1);

    // clr_err outside FAULT is ignored
    step(5'd2, 1'b1);
    chk("clr_in_track_locked", 32'(bus.locked), 32'd1);
    chk("clr_in_track_err",    32'(bus.err),    32'd0);

    // skip fault
    step(5'd3, 1'b0);
    step(5'd4, 1'b0);
    step(5'd5, 1'b0);
    step(5'd7, 1'b0);
    chk("skip_err",     32'(bus.err),     32'd1);
    chk("skip_locked",  32'(bus.locked),  32'd0);
    chk("skip_err_cnt", 32'(bus.err_cnt), 32'd1);
    step(5'd8, 1'b0);
    step(5'd9, 1'b0);
    step(5'd9, 1'b0);
    step(5'd10, 1'b0);
    chk("fault_err_cnt_hold", 32'(bus.err_cnt),  32'd1);
    chk("fault_err_hold",     32'(bus.err),      32'd1);
    chk("fault_state",        32'(dut.state_q),  32'(FAULT));

    // recovery
    step(5'd20, 1'b1);
    chk("clr_err",        32'(bus.err),     32'd0);
    chk("clr_locked",     32'(bus.locked),  32'd0);
    chk("clr_keeps_cnt",  32'(bus.err_cnt), 32'd1);
    step(5'd21, 1'b0);
    chk("relock_e1", 32'(bus.locked), 32'd0);
    step(5'd22, 1'b0);
    chk("relock_e2", 32'(bus.locked), 32'd0);
    step(5'd23, 1'b0);
    chk("relock_e3", 32'(bus.locked), 32'd1);

    // build up wrap_cnt to 3
    for (int c = 24; c <= 31; c++) step(5'(c), 1'b0);
    step(5'd0, 1'b0);
    for (int c = 1; c <= 31; c++) step(5'(c), 1'b0);
    step(5'd0, 1'b0);
    chk("wrap_cnt_3",    32'(bus.wrap_cnt), 32'd3);
    chk("pre_rst_err_cnt", 32'(bus.err_cnt), 32'd1);

    // reset mid-track dominates clr_err
    rst = 1'b1;
    step(5'd5, 1'b1);
    chk("mid_rst_locked",   32'(bus.locked),   32'd0);
    chk("mid_rst_err_cnt",  32'(bus.err_cnt),  32'd0);
    chk("mid_rst_wrap_cnt", 32'(bus.wrap_cnt), 32'd0);
    chk("mid_rst_wrap",     32'(bus.wrap),     32'd0);
    chk("mid_rst_state",    32'(dut.state_q),  32'(ACQ));
    rst = 1'b0;

    // lock noise: bad step in LOCK resets run, raises no error
    step(5'd0, 1'b0);
    step(5'd1, 1'b0);
    step(5'd5, 1'b0);
    chk("noise_err",    32'(bus.err),    32'd0);
    chk("noise_locked", 32'(bus.locked), 32'd0);
    step(5'd6, 1'b0);
    chk("noise_e4", 32'(bus.locked), 32'd0);
    step(5'd7, 1'b0);
    chk("noise_locked_7", 32'(bus.locked),  32'd1);
    chk("noise_err_cnt",  32'(bus.err_cnt), 32'd0);

    // err_cnt saturation at 255
    rst = 1'b1;
    step(5'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 255; i++) begin
      step(5'd0, 1'b1);
      step(5'd1, 1'b0);
      step(5'd2, 1'b0);
      step(5'd3, 1'b0);
      step(5'd3, 1'b0);
    end
    chk("sat_255", 32'(bus.err_cnt), 32'd255);
    step(5'd0, 1'b1);
    step(5'd1, 1'b0);
    step(5'd2, 1'b0);
    step(5'd3, 1'b0);
    step(5'd3, 1'b0);
    chk("sat_hold",     32'(bus.err_cnt), 32'd255);
    chk("sat_err",      32'(bus.err),     32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/count_checker.md
# count_checker

Downstream monitor for the free-running 5-bit count stream produced by the counter stage. It samples the count every clock and verifies that each new value equals the previous value plus one, modulo 2^WIDTH. It locks onto a clean sequence and raises a sticky fault on any skip or stall. It also reports wrap-around events, keeps a wrap tally, and flags when the count reaches a programmable value.

## Interface
- WIDTH, 5: bit width of the monitored count.
- LOCK_CNT, 2: number of consecutive good steps needed to lock (≥1).
- MATCH_VAL, 31: count value that fires `match` (must fit in WIDTH).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cnt_in  in  WIDTH  count from the upstream counter, sampled every posedge.
- clr_err  in  1  clears a fault; honoured only in FAULT.
- locked  out  1  high while in TRACK.
- err  out  1  sticky fault flag.
- err_cnt  out  8  number of faults detected; saturates at 255.
- wrap  out  1  one-cycle pulse on a good (2^WIDTH−1)→0 step while in TRACK.
- wrap_cnt  out  8  number of wrap pulses; wraps 255→0.
- match  out  1  one-cycle pulse when the sampled cnt_in == MATCH_VAL.

## Operation
- Internal `prev` register holds the last sample and updates from cnt_in on every non-reset edge, in all states.
- good step: cnt_in == prev + 1, truncated to WIDTH bits, so 31→0 is good at WIDTH=5.
- FSM states: ACQ, LOCK, TRACK, FAULT.
  - ACQ: captures prev only; no step check is made. Next state is LOCK and run is cleared to 0.
  - LOCK: on a good step, run++. When run+1 == LOCK_CNT, go to TRACK and set locked to 1. On a bad step, clear run to 0 and stay in LOCK; no error is raised.
  - TRACK: a good step stays in TRACK. A bad step goes to FAULT with err←1, locked←0, and err_cnt incremented with saturation.
  - FAULT: err holds at 1. Further bad steps do not increment err_cnt. When clr_err=1, go to ACQ and set err←0.
- wrap and wrap_cnt update only in TRACK, on a good step where prev == 2^WIDTH−1.
- match is state-independent: match ← (cnt_in == MATCH_VAL) on every non-reset edge.
- err_cnt and wrap_cnt are cleared only by rst; clr_err does not clear them.

## Timing
- All outputs are registered and reflect the sample taken at the same edge, so they are visible the cycle after cnt_in is presented.
- Reset values: state=ACQ, prev=0, run=0, locked=0, err=0, err_cnt=0, wrap=0, wrap_cnt=0, match=0.
- rst dominates every other input, including clr_err.
- Lock latency from reset release is 1 + LOCK_CNT edges: with LOCK_CNT=2, locked goes high after the third edge.
- clr_err asserted outside FAULT is ignored. clr_err held high in FAULT leaves FAULT after exactly one edge.
- Leaving FAULT returns to ACQ, so relocking costs another 1 + LOCK_CNT edges.
- Reset mid-TRACK drops locked and clears both counters on the same edge.
- A bad step that would be the 256th fault leaves err_cnt at 255.
- A stalled count (cnt_in == prev) is a bad step.

## Structure
- Package `count_checker_pkg` holds:
  - the state encoding (2-bit localparams: ACQ=0, LOCK=1, TRACK=2, FAULT=3);
  - the default WIDTH;
  - the counter width constant (8).
- One sub-module, `step_check`, contains:
  - the `prev` register;
  - combinational `good_step` and `is_wrap` outputs, with clk, rst and cnt_in as inputs.
- The FSM, counters and output registers live in the top module.

## Test plan
- Clean lock: rst, then cnt_in 0,1,2,3… → locked=1 after the 3rd edge; err=0; err_cnt=0.
- Wrap: locked, feed 30,31,0,1 → wrap pulses high for exactly one cycle after the 31→0 sample; wrap_cnt=1; match pulses once after the 31 sample.
- Skip fault: locked at 5, feed 7 → err=1, locked=0, err_cnt=1. Continue 8,9,9,10 → err_cnt stays 1 and state remains FAULT.
- Recovery: in FAULT, assert clr_err one cycle with count 20,21,22,23 → err=0 the next cycle, then locked=1 two good steps later.
- Lock noise: after rst, feed 0,1,5,6,7 → no err; run resets at 5; locked after the 7 sample.
- Reset mid-operation: locked with wrap_cnt=3 and err_cnt=1, assert rst with clr_err=1 → all outputs 0 the next cycle; state ACQ.
